// File: rtl/fetch_line_buffer.sv
`timescale 1ns/1ps
// Line-granular instruction fetch: one outstanding icache request, DEPTH-entry line FIFO, per-word decode handshake.
// Build option FETCH_BUF_BYPASS_EN forwards an arriving line straight to decode when the FIFO is empty.
module fetch_line_buffer #(
    parameter int              ADDR_W   = 40,
    parameter int              LINE_W   = 128,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 40'h0000000100
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       redirect_valid_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       icache_req_valid_o,
    output logic [ADDR_W-1:0]          icache_req_vaddr_o,
    input  logic                       icache_req_ready_i,
    input  logic                       icache_resp_valid_i,
    input  logic [LINE_W-1:0]          icache_resp_data_i,
    input  logic [1:0]                 icache_resp_xcpt_i,
    output logic                       inst_valid_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_pc_o,
    output logic [1:0]                 inst_xcpt_o,
    input  logic                       inst_ready_i,
    output logic [$clog2(DEPTH):0]     buf_count_o
);

    localparam int LB    = LINE_W / 8;
    localparam int IPL   = LINE_W / INST_W;
    localparam int OFF_W = $clog2(LB);
    localparam int WO_W  = OFF_W - 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {REQ, WAIT, DRAIN, HALT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, deq_pc_q;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mis_q;
    logic                halt_after_drain_q;
    logic [LINE_W-1:0]   line_q [DEPTH];
    logic [1:0]          xcpt_q [DEPTH];

    logic [ADDR_W-1:0]   fetch_line_pc;
    logic [WO_W-1:0]     word_off;
    logic                fifo_empty, redirect_mis, req_fire, resp_take, bypass;
    logic                deq_fire, leaving_line, push, pop, outstanding;
    logic [LINE_W-1:0]   out_line;
    logic [1:0]          out_xcpt;

    assign fetch_line_pc = {fetch_pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign word_off      = deq_pc_q[OFF_W-1:2];
    assign fifo_empty    = (count_q == '0);
    assign redirect_mis  = (redirect_pc_i[1:0] != 2'b00);
    assign resp_take     = (state_q == WAIT) && icache_resp_valid_i && !redirect_valid_i;

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass = fifo_empty && !mis_q && resp_take;
`else
    assign bypass = 1'b0;
`endif

    assign icache_req_valid_o = rstn_i && (state_q == REQ) && (count_q < CNT_W'(DEPTH));
    assign icache_req_vaddr_o = fetch_line_pc;
    assign req_fire           = icache_req_valid_o && icache_req_ready_i;

    always_comb begin
        out_line     = line_q[rd_ptr_q];
        out_xcpt     = xcpt_q[rd_ptr_q];
        if (bypass) begin
            out_line = icache_resp_data_i;
            out_xcpt = icache_resp_xcpt_i;
        end
        inst_valid_o = (!fifo_empty || mis_q || bypass) && !redirect_valid_i;
        inst_o       = mis_q ? '0 : out_line[word_off*INST_W +: INST_W];
        inst_xcpt_o  = mis_q ? 2'b11 : out_xcpt;
        inst_pc_o    = deq_pc_q;
    end

    // A faulting line delivers only the instruction at the current offset.
    assign deq_fire     = inst_valid_o && inst_ready_i;
    assign leaving_line = (word_off == WO_W'(IPL - 1)) || (out_xcpt != 2'b00);
    assign pop          = deq_fire && !mis_q && !bypass && leaving_line;
    assign push         = resp_take && !(bypass && deq_fire && leaving_line);
    assign count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    assign buf_count_o  = count_q;

    // A response still owed by the icache after this cycle must be drained before refetching.
    assign outstanding = (((state_q == WAIT) || (state_q == DRAIN)) && !icache_resp_valid_i) ||
                         ((state_q == REQ) && req_fire);

    always_comb begin
        state_d = state_q;
        if (redirect_valid_i) begin
            if (outstanding)       state_d = DRAIN;
            else if (redirect_mis) state_d = HALT;
            else                   state_d = REQ;
        end else begin
            case (state_q)
                REQ:     if (req_fire) state_d = WAIT;
                WAIT:    if (icache_resp_valid_i)
                             state_d = (icache_resp_xcpt_i != 2'b00) ? HALT : REQ;
                DRAIN:   if (icache_resp_valid_i)
                             state_d = halt_after_drain_q ? HALT : REQ;
                default: state_d = HALT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q            <= REQ;
            fetch_pc_q         <= RESET_PC;
            deq_pc_q           <= RESET_PC;
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            count_q            <= '0;
            mis_q              <= 1'b0;
            halt_after_drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_valid_i) begin
                fetch_pc_q         <= redirect_pc_i;
                deq_pc_q           <= redirect_pc_i;
                rd_ptr_q           <= '0;
                wr_ptr_q           <= '0;
                count_q            <= '0;
                mis_q              <= redirect_mis;
                halt_after_drain_q <= redirect_mis;
            end else begin
                if (resp_take) fetch_pc_q <= fetch_line_pc + ADDR_W'(LB);
                if (push)      wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                if (pop)       rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
                if (deq_fire) begin
                    deq_pc_q <= deq_pc_q + ADDR_W'(4);
                    mis_q    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            line_q[wr_ptr_q] <= icache_resp_data_i;
            xcpt_q[wr_ptr_q] <= icache_resp_xcpt_i;
        end
    end

endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Parametrised successor to the single-request icache interface. It issues line-aligned fetch requests to the icache and buffers up to DEPTH returned lines.
- It slices each buffered line into INST_W-bit instructions and hands them to decode with a valid/ready handshake.
- It handles redirects (jumps from decode or commit), discarding any in-flight response, and carries fetch exceptions to the consuming instruction.

Parameters:
ADDR_W, 40, virtual address width
LINE_W, 128, icache line width in bits; power of 2, >= 2*INST_W
INST_W, 32, instruction width
DEPTH, 4, buffered line entries; power of 2, >= 2
RESET_PC, 40'h0000000100, first fetch address after reset

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
redirect_valid_i  in  1  flush buffer and restart fetch at redirect_pc_i
redirect_pc_i  in  ADDR_W  redirect target
icache_req_valid_o  out  1  request valid
icache_req_vaddr_o  out  ADDR_W  line-aligned request address
icache_req_ready_i  in  1  icache accepts request
icache_resp_valid_i  in  1  line response valid
icache_resp_data_i  in  LINE_W  line data
icache_resp_xcpt_i  in  2  00 none, 01 access fault, 10 page fault
inst_valid_o  out  1  instruction valid to decode
inst_o  out  INST_W  instruction
inst_pc_o  out  ADDR_W  instruction PC
inst_xcpt_o  out  2  00 none, 01 access fault, 10 page fault, 11 misaligned
inst_ready_i  in  1  decode accepts instruction
buf_count_o  out  $clog2(DEPTH)+1  valid line entries

Behaviour:

Derived constants
- LB = LINE_W/8 bytes per line.
- IPL = LINE_W/INST_W instructions per line.

Registers
- fetch_pc: next line to request.
- deq_pc: PC of the head instruction.
- Line FIFO of DEPTH entries {line, xcpt}, with rd/wr pointers that wrap modulo DEPTH.

FSM states: REQ, WAIT, DRAIN, HALT.
- Reset: state REQ; fetch_pc = deq_pc = RESET_PC; FIFO empty; all outputs 0.
- REQ:
  - icache_req_valid_o = 1 only when (count + 0) < DEPTH.
  - icache_req_vaddr_o = fetch_pc with low log2(LB) bits cleared.
  - On valid & ready, go to WAIT.
- WAIT: on icache_resp_valid_i:
  - Push {data, xcpt} and set fetch_pc = aligned fetch_pc + LB.
  - If xcpt != 0, go to HALT; otherwise go to REQ.
- DRAIN: the killed response is outstanding. Discard the next icache_resp_valid_i, then go to REQ.
- HALT: issue no requests until a redirect.
- At most one request is outstanding. Space is reserved at issue, so a push never overflows.

Output path
- inst_valid_o = FIFO non-empty and no redirect this cycle.
- Word offset o = deq_pc[log2(LB)-1:2]; inst_o = head.line[o*INST_W +: INST_W].
- inst_pc_o = deq_pc; inst_xcpt_o = head.xcpt.
- On valid & ready:
  - deq_pc += 4.
  - If o == IPL-1, pop the head.
  - If head.xcpt != 0, pop the head regardless of o; the faulting instruction is the only one delivered from that line.
- Latency: response accepted at cycle N gives inst_valid_o at N+1.

Redirect (highest priority)
- Next cycle: FIFO empty; fetch_pc = deq_pc = redirect_pc_i.
- State becomes DRAIN if currently WAIT, else REQ.
- A response or handshake arriving in the same cycle as the redirect is ignored.
- A pending REQ that was accepted in the redirect cycle also goes to DRAIN.

Misaligned redirect
- Applies when redirect_pc_i[1:0] != 0.
- No icache request is issued; state is HALT.
- A single pseudo-entry is presented: inst_o = 0, inst_xcpt_o = 11, inst_pc_o = redirect PC. It pops on handshake.

Other rules
- The first line after a redirect starts at the redirect offset; words below that offset are never delivered.
- buf_count_o counts only valid line entries.
- Reset asserted mid-operation clears everything; any outstanding response after reset release is ignored because state is REQ with no tracking. The icache is also reset.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state is WAIT and icache_resp_valid_i is high, the response is presented on inst_* combinationally in the same cycle (latency 0).
  - If it is accepted and it is the last word, or it faults, it is not written to the FIFO.
  - A redirect still blocks the bypass.
- Undefined: latency is fixed at 1 cycle; no combinational path from icache_resp_* to inst_*.

Test Plan:
- Reset, icache responds after 2 cycles with line 0x44443333_22221111_... at 0x100, inst_ready_i = 1 → insts 0x..., PCs 0x100, 0x104, 0x108, 0x10C in consecutive cycles; next request vaddr 0x110.
- Hold inst_ready_i = 0, icache always ready → exactly 4 requests issued; buf_count_o = 4; icache_req_valid_o stays 0 until the first pop.
- Redirect to 0x208 while in WAIT → next response discarded; next request vaddr 0x200; first inst_pc_o = 0x208, then 0x20C; buf_count_o = 0 the cycle after the redirect.
- Response with xcpt = 10 at line 0x300 after redirect to 0x304 → one instruction at PC 0x304 with inst_xcpt_o = 10; no further requests until a redirect.
- Redirect to 0x402 → inst_valid_o = 1, inst_xcpt_o = 11, inst_pc_o = 0x402, no icache request.
- Redirect, response and inst handshake in the same cycle → FIFO empty next cycle; deq_pc = redirect PC; the handshaked instruction is not consumed twice.
